// File: rtl/da_pkg.sv
// Shared types and constants for the waveform playback controller.
package da_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    // Offset-binary midscale: XOR with this flips the sign bit of a 16-bit sample.
    localparam logic [15:0] MIDSCALE = 16'h8000;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_t;

endpackage

// File: rtl/da_ctrl_if.sv
// Control/data bundle between a host (master) and the playback controller (slave).
interface da_ctrl_if
    import da_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              stop;
    logic [ADDR_W-1:0] play_len;
    logic              loop;
    logic              fmt_signed;
    logic [DATA_W-1:0] da_data;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_idx;

    modport master (
        output wr_en, wr_addr, wr_data, start, stop, play_len, loop, fmt_signed,
        input  da_data, busy, done, rd_idx
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, start, stop, play_len, loop, fmt_signed,
        output da_data, busy, done, rd_idx
    );
endinterface

// File: rtl/da_ram.sv
// Waveform buffer: simple dual-port RAM, one write port, one registered read port.
module da_ram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              sample_clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM and keeps its
    // contents through rst_n; non-blocking writes make a same-address read
    // see the old word (read-first).
    always_ff @(posedge sample_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/da_ctrl.sv
// DAC playback controller: plays buffer[0..play_len] once or in a loop,
// two-cycle pipeline (RAM read, output register) from start to first sample.
module da_ctrl
    import da_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic       sample_clk,
    input  logic       rst_n,
    da_ctrl_if.slave   bus
);
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] rd_idx;
    logic              loop_q;
    logic              fmt_q;
    logic              rd_vld;
    logic              rd_last;
    logic              done_q;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] da_q;

    logic launch, kill, playing, at_end;

    assign launch  = (state == IDLE) && bus.start && !bus.stop;
    assign kill    = (state == PLAY) && bus.stop;
    assign playing = (state == PLAY) && !bus.stop;
    assign at_end  = (rd_idx == len_q);

    da_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
        .sample_clk,
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (rd_idx),
        .rd_data (rd_word)
    );

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (launch) state_nxt = PLAY;
            PLAY: begin
                if (bus.stop) begin
                    state_nxt = IDLE;
                end else if (at_end && !loop_q) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sample_clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q   <= '0;
            loop_q  <= 1'b0;
            fmt_q   <= 1'b0;
            rd_idx  <= '0;
            rd_vld  <= 1'b0;
            rd_last <= 1'b0;
            da_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            if (launch) begin
                len_q  <= bus.play_len;
                loop_q <= bus.loop;
                fmt_q  <= bus.fmt_signed;
                rd_idx <= '0;
            end else if (playing) begin
                rd_idx <= at_end ? '0 : rd_idx + 1'b1;
            end

            // A stop discards the read issued this cycle and the one already in flight.
            rd_vld  <= playing;
            rd_last <= playing && at_end && !loop_q;

            if (rd_vld && !kill) begin
                da_q <= fmt_q ? {~rd_word[DATA_W-1], rd_word[DATA_W-2:0]} : rd_word;
            end
            done_q <= rd_vld && rd_last && !kill;
        end
    end

    assign bus.da_data = da_q;
    assign bus.busy    = (state == PLAY);
    assign bus.done    = done_q;
    assign bus.rd_idx  = rd_idx;

endmodule

// File: tb/tb_da_ctrl.sv
// Directed bench for da_ctrl: table of playback runs plus hand sequences
// for stop, ignored start, read-first writes, reset and single-sample loops.
module tb_da_ctrl;
    import da_pkg::*;

    typedef struct packed {
        logic             fmt;
        logic             lp;
        logic [7:0]       len;
        logic [7:0]       n;
        logic [7:0]       done_at;   // 8'hFF: done never expected
        logic [11:0][15:0] exp;
    } run_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    run_t tbl [3];
    run_t r_post;

    da_ctrl_if #(.DATA_W(16), .ADDR_W(8)) bus ();

    da_ctrl dut (
        .sample_clk (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [15:0] data);
        bus.wr_en = 1'b1; bus.wr_addr = addr; bus.wr_data = data;
        tick();
        bus.wr_en = 1'b0;
    endtask

    task automatic launch(input logic fmt, input logic lp, input logic [7:0] len);
        bus.fmt_signed = fmt; bus.loop = lp; bus.play_len = len; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic play_run(input run_t r, input string tag);
        launch(r.fmt, r.lp, r.len);
        tick();
        for (int k = 0; k < int'(r.n); k++) begin
            tick();
            check({tag, "_data"}, 32'(bus.da_data), 32'(r.exp[k]));
            check({tag, "_done"}, 32'(bus.done), 32'(k == int'(r.done_at)));
            check({tag, "_busy"}, 32'(bus.busy), 32'(r.lp || (k + 2 <= int'(r.len))));
        end
        if (r.lp) bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_end_done"}, 32'(bus.done), 32'd0);
        check({tag, "_hold"}, 32'(bus.da_data), 32'(r.exp[int'(r.n) - 1]));
        tick();
        tick();
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.stop = 1'b0; bus.play_len = '0;
        bus.loop = 1'b0; bus.fmt_signed = 1'b0;
        rst_n = 1'b0;

        // one-shot, offset-binary
        tbl[0] = '0;
        tbl[0].fmt = 1'b1; tbl[0].lp = 1'b0; tbl[0].len = 8'd3; tbl[0].n = 8'd4; tbl[0].done_at = 8'd3;
        tbl[0].exp[0] = 16'h8000; tbl[0].exp[1] = 16'hFFFF; tbl[0].exp[2] = 16'h0000; tbl[0].exp[3] = 16'h7FFF;
        // looping raw, three full periods
        tbl[1] = '0;
        tbl[1].fmt = 1'b0; tbl[1].lp = 1'b1; tbl[1].len = 8'd3; tbl[1].n = 8'd12; tbl[1].done_at = 8'hFF;
        for (int p = 0; p < 3; p++) begin
            tbl[1].exp[4*p+0] = 16'h0000; tbl[1].exp[4*p+1] = 16'h7FFF;
            tbl[1].exp[4*p+2] = 16'h8000; tbl[1].exp[4*p+3] = 16'hFFFF;
        end
        // short one-shot, offset-binary
        tbl[2] = '0;
        tbl[2].fmt = 1'b1; tbl[2].lp = 1'b0; tbl[2].len = 8'd1; tbl[2].n = 8'd2; tbl[2].done_at = 8'd1;
        tbl[2].exp[0] = 16'h8000; tbl[2].exp[1] = 16'hFFFF;
        // raw one-shot replay after reset
        r_post = '0;
        r_post.fmt = 1'b0; r_post.lp = 1'b0; r_post.len = 8'd3; r_post.n = 8'd4; r_post.done_at = 8'd3;
        r_post.exp[0] = 16'h0000; r_post.exp[1] = 16'h7FFF; r_post.exp[2] = 16'h8000; r_post.exp[3] = 16'hFFFF;

        tick(); tick();
        check("rst_data", 32'(bus.da_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_idx", 32'(bus.rd_idx), 32'd0);
        rst_n = 1'b1;
        tick();

        wr(8'd0, 16'h0000); wr(8'd1, 16'h7FFF); wr(8'd2, 16'h8000); wr(8'd3, 16'hFFFF);

        for (int i = 0; i < 3; i++) play_run(tbl[i], $sformatf("run%0d", i));

        // loop with a start ignored mid-run, then stop at index 2
        launch(1'b1, 1'b1, 8'd3);               // m=0
        tick(); tick(); tick();                 // m=3
        check("ign_pre_data", 32'(bus.da_data), 32'h0000FFFF);
        bus.start = 1'b1; bus.play_len = 8'd0; bus.fmt_signed = 1'b0;
        tick();                                 // m=4
        bus.start = 1'b0; bus.play_len = 8'd3;
        check("ign_busy", 32'(bus.busy), 32'd1);
        check("ign_data4", 32'(bus.da_data), 32'h00000000);
        tick();                                 // m=5
        check("ign_idx5", 32'(bus.rd_idx), 32'd1);
        check("ign_data5", 32'(bus.da_data), 32'h00007FFF);
        tick();                                 // m=6
        check("stop_idx", 32'(bus.rd_idx), 32'd2);
        check("stop_pre_data", 32'(bus.da_data), 32'h00008000);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("stop_busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check("stop_hold", 32'(bus.da_data), 32'h00008000);
            check("stop_done", 32'(bus.done), 32'd0);
            tick();
        end

        // write to the index being read: old word this pass, new word next pass
        launch(1'b0, 1'b1, 8'd3);               // m=0
        tick();                                 // m=1
        check("rf_idx", 32'(bus.rd_idx), 32'd1);
        bus.wr_en = 1'b1; bus.wr_addr = 8'd1; bus.wr_data = 16'h5555;
        tick();                                 // m=2
        bus.wr_en = 1'b0;
        tick();                                 // m=3
        check("rf_old", 32'(bus.da_data), 32'h00007FFF);
        tick(); tick(); tick(); tick();         // m=7
        check("rf_new", 32'(bus.da_data), 32'h00005555);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        wr(8'd1, 16'h7FFF);

        // start and stop together in IDLE
        bus.start = 1'b1; bus.stop = 1'b1; bus.fmt_signed = 1'b0; bus.loop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        check("ss_busy0", 32'(bus.busy), 32'd0);
        tick();
        check("ss_busy1", 32'(bus.busy), 32'd0);
        check("ss_hold", 32'(bus.da_data), 32'h00005555);

        // asynchronous reset mid-playback, then replay from retained buffer
        launch(1'b0, 1'b1, 8'd3);
        tick(); tick(); tick(); tick();         // m=4
        check("pre_rst_data", 32'(bus.da_data), 32'h00008000);
        #2 rst_n = 1'b0;
        #1;
        check("arst_data", 32'(bus.da_data), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_idx", 32'(bus.rd_idx), 32'd0);
        @(negedge clk);
        tick();
        rst_n = 1'b1;
        tick();
        play_run(r_post, "post_rst");

        // single-sample loop
        wr(8'd0, 16'h1234);
        launch(1'b0, 1'b1, 8'd0);
        tick();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("one_data", 32'(bus.da_data), 32'h00001234);
            check("one_idx", 32'(bus.rd_idx), 32'd0);
            check("one_done", 32'(bus.done), 32'd0);
        end
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check("one_end_busy", 32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
